// File: rtl/byte_data_memory.sv
// Byte-addressed little-endian data memory with a valid/ready request port and a
// fixed-latency in-order response pipeline carrying load data and an error flag.
module byte_data_memory #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rsp_error
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BZX  = 2'b01;
  localparam logic [1:0] SZ_BSX  = 2'b10;
  localparam logic [1:0] SZ_RSV  = 2'b11;

  logic [7:0]                 mem [DEPTH];
  logic                       accept;
  logic                       err;
  logic [ADDR_WIDTH:0]        last;
  logic [NB-1:0][IW-1:0]      idx;
  logic [NB-1:0][7:0]         rbytes;
  logic [DATA_WIDTH-1:0]      ldata;

  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] data_pipe;
  logic [READ_LATENCY:1]                 err_pipe;

  assign accept = req_valid & req_ready;

  // Bounds check is one bit wider than the address so a top-of-space access cannot wrap.
  always_comb begin
    last = {1'b0, address} + ((req_size == SZ_WORD) ? (ADDR_WIDTH+1)'(NB-1) : '0);
    err  = (req_size == SZ_RSV) || (last >= LIMIT);
  end

  for (genvar i = 0; i < NB; i++) begin : g_byte
    assign idx[i]    = IW'(address + ADDR_WIDTH'(i));
    assign rbytes[i] = mem[idx[i]];
  end

  always_comb begin
    ldata = '0;
    if (!err && !req_write) begin
      case (req_size)
        SZ_WORD: ldata = rbytes;
        SZ_BZX:  ldata = DATA_WIDTH'(rbytes[0]);
        SZ_BSX:  ldata = {{(DATA_WIDTH-8){rbytes[0][7]}}, rbytes[0]};
        default: ldata = '0;
      endcase
    end
  end

  // Storage is deliberately left unreset; errored requests never reach it.
  always_ff @(posedge clk) begin
    if (accept && req_write && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (i == 0 || req_size == SZ_WORD) mem[idx[i]] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) req_ready <= 1'b0;
    else       req_ready <= 1'b1;
  end

  // Each stage loads only when a response enters it, so the last stage holds its value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe  <= '0;
      data_pipe <= '0;
      err_pipe  <= '0;
    end else begin
      vld_pipe[1] <= accept;
      if (accept) begin
        data_pipe[1] <= ldata;
        err_pipe[1]  <= err;
      end
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) begin
          data_pipe[k] <= data_pipe[k-1];
          err_pipe[k]  <= err_pipe[k-1];
        end
      end
    end
  end

  assign rsp_valid = vld_pipe[READ_LATENCY];
  assign rdata     = data_pipe[READ_LATENCY];
  assign rsp_error = err_pipe[READ_LATENCY];
endmodule

// File: tb/tb_byte_data_memory.sv
// Scoreboard bench for byte_data_memory: stimulus pushes expected responses with their
// due cycle; an independent monitor pops and checks every rsp_valid.
module tb_byte_data_memory;
  localparam int DW = 16, AW = 16, DEPTH = 256, L = 2;

  logic          clk = 1'b0, reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] wdata = '0;
  logic          req_ready, rsp_valid, rsp_error;
  logic [DW-1:0] rdata;

  byte_data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .address(address), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .rsp_error(rsp_error));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [DW-1:0] data; logic err; int id;} exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0, n_issued = 0;

  task automatic chk(string name, int id, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s id=%0d actual=0x%0h required=0x%0h", name, id, act, exp);
    end
  endtask

  // Monitor: any response with nothing outstanding is an error.
  always @(posedge clk) begin
    #1;
    if (rsp_valid) begin
      if (q.size() == 0) begin
        compared++; mismatched++;
        $display("FAIL unexpected_rsp cyc=%0d actual rsp_valid=1 required 0", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_cycle", e.id, 64'(cyc), 64'(e.due));
        chk("rdata", e.id, 64'(rdata), 64'(e.data));
        chk("rsp_error", e.id, 64'(rsp_error), 64'(e.err));
      end
    end
  end

  task automatic issue(bit wr, logic [1:0] sz, logic [AW-1:0] a, logic [DW-1:0] wd,
                       logic [DW-1:0] ed, bit ee);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; address = a; wdata = wd;
    q.push_back('{due: cyc + L, data: ed, err: ee, id: n_issued});
    n_issued++;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    chk("ready_before_edge", -1, 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_release", -1, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    mismatched++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", -1, 64'(req_ready), 64'd0);
    chk("rst_valid", -1, 64'(rsp_valid), 64'd0);
    chk("rst_rdata", -1, 64'(rdata), 64'd0);
    chk("rst_error", -1, 64'(rsp_error), 64'd0);
    release_reset();

    // Word store then loads
    issue(1, 2'b00, 16'h0010, 16'hA5F0, 16'h0000, 0);
    issue(0, 2'b00, 16'h0010, 16'h0000, 16'hA5F0, 0);
    issue(0, 2'b01, 16'h0011, 16'h0000, 16'h00A5, 0);
    idle(L + 2);
    chk("hold_valid", -1, 64'(rsp_valid), 64'd0);
    chk("hold_rdata", -1, 64'(rdata), 64'h00A5);

    // Byte store leaves neighbour intact, sign/zero extension
    issue(1, 2'b00, 16'h0020, 16'h1234, 16'h0000, 0);
    issue(1, 2'b01, 16'h0020, 16'h5580, 16'h0000, 0);
    issue(0, 2'b00, 16'h0020, 16'h0000, 16'h1280, 0);
    issue(0, 2'b10, 16'h0020, 16'h0000, 16'hFF80, 0);
    issue(0, 2'b01, 16'h0020, 16'h0000, 16'h0080, 0);
    idle(L + 2);

    // Bounds and reserved size
    issue(1, 2'b00, 16'h00FE, 16'h6655, 16'h0000, 0);
    issue(0, 2'b00, 16'h00FE, 16'h0000, 16'h6655, 0);
    issue(0, 2'b10, 16'h00FF, 16'h0000, 16'h0066, 0);
    issue(0, 2'b00, 16'h00FF, 16'h0000, 16'h0000, 1);
    issue(1, 2'b00, 16'h00FF, 16'hAAAA, 16'h0000, 1);
    issue(0, 2'b01, 16'h00FF, 16'h0000, 16'h0066, 0);
    issue(0, 2'b01, 16'h0100, 16'h0000, 16'h0000, 1);
    issue(0, 2'b00, 16'hFFFF, 16'h0000, 16'h0000, 1);
    issue(0, 2'b11, 16'h0010, 16'h0000, 16'h0000, 1);
    issue(1, 2'b00, 16'h0030, 16'h1111, 16'h0000, 0);
    issue(1, 2'b11, 16'h0030, 16'hBEEF, 16'h0000, 1);
    issue(0, 2'b00, 16'h0030, 16'h0000, 16'h1111, 0);
    issue(0, 2'b00, 16'h00FE, 16'h0000, 16'h6655, 0);
    idle(L + 2);

    // Back-to-back pipelined loads, including misaligned words
    issue(1, 2'b00, 16'h0010, 16'h0201, 16'h0000, 0);
    issue(1, 2'b00, 16'h0012, 16'h0403, 16'h0000, 0);
    issue(1, 2'b01, 16'h0014, 16'h0005, 16'h0000, 0);
    issue(0, 2'b00, 16'h0010, 16'h0000, 16'h0201, 0);
    issue(0, 2'b00, 16'h0011, 16'h0000, 16'h0302, 0);
    issue(0, 2'b00, 16'h0012, 16'h0000, 16'h0403, 0);
    issue(0, 2'b00, 16'h0013, 16'h0000, 16'h0504, 0);
    idle(L + 2);

    // Reset while a response is on the port and another load is in flight
    issue(1, 2'b00, 16'h0040, 16'hCAFE, 16'h0000, 0);
    idle(L + 2);
    issue(1, 2'b00, 16'h0042, 16'hBEEF, 16'h0000, 0);
    issue(0, 2'b00, 16'h0040, 16'h0000, 16'hCAFE, 0);
    issue(0, 2'b00, 16'h0010, 16'h0000, 16'h0201, 0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_ready", -1, 64'(req_ready), 64'd0);
    chk("midrst_valid", -1, 64'(rsp_valid), 64'd0);
    chk("midrst_rdata", -1, 64'(rdata), 64'd0);
    chk("midrst_error", -1, 64'(rsp_error), 64'd0);
    repeat (2) @(negedge clk);
    release_reset();
    idle(L + 2);
    issue(0, 2'b00, 16'h0042, 16'h0000, 16'hBEEF, 0);
    issue(0, 2'b00, 16'h0040, 16'h0000, 16'hCAFE, 0);
    idle(L + 3);

    chk("queue_empty", -1, 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
